itype_issue_stage: RTL and testbench
====================================

Name: itype_issue_stage

Overview:
Decode/operand-fetch stage that feeds the I-type execute unit: it accepts raw 32-bit instruction words over a valid/ready handshake and reads rs1 from a synchronous-read register file. It presents opcode, funct3, imm, rs1 data and rd to the execute unit over a second valid/ready handshake. It rejects non-OP-IMM or malformed shift encodings and counts them. Two-stage pipeline (A: request, B: output) with full throughput and writeback bypass.

Parameters:
CNT_W, 16, width of saturating illegal-instruction counter
XLEN, 32, data width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_valid  in  1  upstream instruction valid
instr_ready  out  1  stage can accept instruction
instr  in  32  RV32I instruction word
rf_raddr  out  5  register file read address, data returned next cycle
rf_rdata  in  32  register file read data (1-cycle latency)
wb_en  in  1  writeback this cycle
wb_addr  in  5  writeback register
wb_data  in  32  writeback data
dec_valid  out  1  decoded operands valid
dec_ready  in  1  execute unit accepts
opcode  out  7  instr[6:0]
funct3  out  3  instr[14:12]
imm  out  12  instr[31:20]
in1  out  32  rs1 data
rd  out  5  destination register
illegal  out  1  one-cycle pulse per rejected instruction
illegal_count  out  CNT_W  saturating rejected count

Behaviour:
- Reset: all outputs 0, including dec_valid, illegal and illegal_count. Stage A and B are empty. instr_ready = 1 in the first cycle after reset. Reset mid-transfer discards both stages with no output.
- Accept: accept = instr_valid && instr_ready. rf_raddr = instr[19:15] combinationally, driven whenever instr_valid is high.
- Stage A fields: a_valid, a_instr, a_data, a_data_ok.
  - On accept: load a_instr and set a_data_ok = 0.
  - Next cycle: capture in1 candidate into a_data and set a_data_ok = 1. Candidate is 0 if rs1 = 0, else wb_data if (wb_en && wb_addr == rs1), else rf_rdata.
  - While A holds with a_data_ok = 1: any wb_en to a nonzero rs1 overwrites a_data.
- Stage B: a_move = a_valid && (!dec_valid || dec_ready || a_illegal).
  - On a_move with a legal instruction: B loads the fields and in1 = (a_data_ok ? a_data : candidate), and sets dec_valid = 1.
  - On a_move with an illegal instruction: B is not loaded, illegal pulses for 1 cycle, and illegal_count increments, saturating at all-ones.
- instr_ready = !a_valid || a_move. Back-to-back accepts sustain 1 instruction/cycle.
- dec_valid clears after dec_ready handshake unless reloaded the same cycle. Outputs are held stable while dec_valid && !dec_ready.
- Latency: accept at cycle N gives dec_valid at cycle N+2 when no stall.
- Legality (evaluated on a_instr):
  - opcode must be 7'b0010011.
  - funct3 001 requires imm[11:5] = 0000000.
  - funct3 101 requires imm[11:5] ∈ {0000000, 0100000}.
  - All other funct3 values are legal with any imm.
- rd = 0 is legal and forwarded.
- Simultaneous events:
  - wb_en to rs1 in the capture cycle: wb_data wins over rf_rdata.
  - accept and a_move in the same cycle: A reloads, and the old contents go to B.

Decomposition:
- itype_pkg holds:
  - OPCODE_OP_IMM = 7'b0010011
  - funct3 enum: ADDI, SLLI, SLTI, SLTIU, XORI, SRLI_SRAI, ORI, ANDI
  - FUNCT7_ZERO = 7'h00 and FUNCT7_SRA = 7'h20
- Sub-module itype_legal_check: combinational instr → legal flag, reused by the bench scoreboard.

Test Plan:
- Reset, then ADDI x5,x1,-1 (0xFFF08293) with rf_rdata = 0x00000010 → two cycles later dec_valid = 1, opcode = 0x13, funct3 = 0, imm = 0xFFF, in1 = 0x10, rd = 5; rf_raddr = 1 in the accept cycle.
- SRAI x3,x2,4 (0x40415193) accepted; next cycle wb_en = 1, wb_addr = 2, wb_data = 0x80000000, rf_rdata = 0x1 → in1 = 0x80000000, imm = 0x404.
- Stream 4 legal instructions with dec_ready held 0 for 5 cycles → instr_ready drops after 2 accepts, B outputs stay stable, no loss. Release dec_ready → remaining instructions emerge in order, 1 per cycle.
- Illegal 0x40001013 (bad SLLI funct7), then 0x00000033 (R-type) → two illegal pulses, illegal_count = 2, dec_valid never asserts for them.
- rs1 = x0 with rf_rdata = 0xDEADBEEF → in1 = 0. Illegal count preloaded by 2^16+3 illegal instructions → illegal_count = 0xFFFF.
- rst asserted while A and B are full → next cycle dec_valid = 0, instr_ready = 1, illegal_count = 0.

Source files
------------

// File: rtl/itype_pkg.sv
// Shared encodings for the RV32I OP-IMM issue stage: opcode, funct3 names
// and the two funct7 patterns allowed on immediate shifts.
package itype_pkg;

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] FUNCT7_ZERO   = 7'h00;
    localparam logic [6:0] FUNCT7_SRA    = 7'h20;

    typedef enum logic [2:0] {
        ADDI      = 3'b000,
        SLLI      = 3'b001,
        SLTI      = 3'b010,
        SLTIU     = 3'b011,
        XORI      = 3'b100,
        SRLI_SRAI = 3'b101,
        ORI       = 3'b110,
        ANDI      = 3'b111
    } funct3_e;

endpackage

// File: rtl/itype_legal_check.sv
// Combinational legality check for an OP-IMM instruction word: opcode must be
// OP-IMM and shift-immediate encodings must carry a valid funct7.
module itype_legal_check
    import itype_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        legal_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    funct3_e    funct3;

    assign opcode = instr_i[6:0];
    assign funct7 = instr_i[31:25];
    assign funct3 = funct3_e'(instr_i[14:12]);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        legal_o = 1'b0;
        if (opcode == OPCODE_OP_IMM) begin
            case (funct3)
                SLLI:      legal_o = (funct7 == FUNCT7_ZERO);
                SRLI_SRAI: legal_o = (funct7 == FUNCT7_ZERO) || (funct7 == FUNCT7_SRA);
                default:   legal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/itype_issue_stage.sv
// Two-stage OP-IMM decode/operand-fetch: stage A waits for the synchronous
// register-file read, stage B presents decoded operands to the execute unit.
module itype_issue_stage
    import itype_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [4:0]       rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [6:0]       opcode,
    output logic [2:0]       funct3,
    output logic [11:0]      imm,
    output logic [XLEN-1:0]  in1,
    output logic [4:0]       rd,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    // Stage A
    logic            a_valid_q, a_valid_d;
    logic [31:0]     a_instr_q, a_instr_d;
    logic [XLEN-1:0] a_data_q, a_data_d;
    logic            a_data_ok_q, a_data_ok_d;

    // Stage B and status
    logic             dec_valid_q, dec_valid_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [11:0]      imm_q, imm_d;
    logic [XLEN-1:0]  in1_q, in1_d;
    logic [4:0]       rd_q, rd_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

    logic            a_legal;
    logic [4:0]      a_rs1;
    logic            wb_hit;
    logic [XLEN-1:0] candidate;
    logic            accept;
    logic            a_move;
    logic            b_load;

    itype_legal_check u_legal_check (
        .instr_i (a_instr_q),
        .legal_o (a_legal)
    );

    assign a_rs1     = a_instr_q[19:15];
    assign wb_hit    = wb_en && (wb_addr == a_rs1) && (a_rs1 != 5'd0);
    // A writeback landing in the read cycle is newer than the RF read data.
    assign candidate = (a_rs1 == 5'd0) ? '0 : (wb_hit ? wb_data : rf_rdata);

    // Illegal words never occupy B, so they may leave A even while B stalls.
    assign a_move      = a_valid_q && (!dec_valid_q || dec_ready || !a_legal);
    assign b_load      = a_move && a_legal;
    assign instr_ready = !a_valid_q || a_move;
    assign accept      = instr_valid && instr_ready;
    assign rf_raddr    = instr_valid ? instr[19:15] : 5'd0;

    always_comb begin
        a_valid_d   = a_valid_q;
        a_instr_d   = a_instr_q;
        a_data_d    = a_data_q;
        a_data_ok_d = a_data_ok_q;
        if (accept) begin
            a_valid_d   = 1'b1;
            a_instr_d   = instr;
            a_data_ok_d = 1'b0;
        end else begin
            if (a_move) begin
                a_valid_d = 1'b0;
            end
            if (a_valid_q && !a_data_ok_q) begin
                a_data_d    = candidate;
                a_data_ok_d = 1'b1;
            end else if (a_valid_q && wb_hit) begin
                a_data_d = wb_data;
            end
        end
    end

    always_comb begin
        dec_valid_d     = dec_valid_q && !dec_ready;
        opcode_d        = opcode_q;
        funct3_d        = funct3_q;
        imm_d           = imm_q;
        in1_d           = in1_q;
        rd_d            = rd_q;
        illegal_d       = a_move && !a_legal;
        illegal_count_d = illegal_count_q;
        if (b_load) begin
            dec_valid_d = 1'b1;
            opcode_d    = a_instr_q[6:0];
            funct3_d    = a_instr_q[14:12];
            imm_d       = a_instr_q[31:20];
            in1_d       = a_data_ok_q ? a_data_q : candidate;
            rd_d        = a_instr_q[11:7];
        end
        if (illegal_d && (illegal_count_q != '1)) begin
            illegal_count_d = illegal_count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q       <= 1'b0;
            a_data_ok_q     <= 1'b0;
            dec_valid_q     <= 1'b0;
            opcode_q        <= '0;
            funct3_q        <= '0;
            imm_q           <= '0;
            in1_q           <= '0;
            rd_q            <= '0;
            illegal_q       <= 1'b0;
            illegal_count_q <= '0;
        end else begin
            a_valid_q       <= a_valid_d;
            a_data_ok_q     <= a_data_ok_d;
            dec_valid_q     <= dec_valid_d;
            opcode_q        <= opcode_d;
            funct3_q        <= funct3_d;
            imm_q           <= imm_d;
            in1_q           <= in1_d;
            rd_q            <= rd_d;
            illegal_q       <= illegal_d;
            illegal_count_q <= illegal_count_d;
        end
    end

    // NOTE: stage-A payload needs no reset; it is only observed while a_valid_q is set.
    always_ff @(posedge clk) begin
        a_instr_q <= a_instr_d;
        a_data_q  <= a_data_d;
    end

    assign dec_valid     = dec_valid_q;
    assign opcode        = opcode_q;
    assign funct3        = funct3_q;
    assign imm           = imm_q;
    assign in1           = in1_q;
    assign rd            = rd_q;
    assign illegal       = illegal_q;
    assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_itype_issue_stage.sv
// Directed bench for itype_issue_stage: inputs driven 1ns after the rising
// edge, outputs sampled 1ns later, expected values written out by hand.
module tb_itype_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [31:0] in1;
    logic [4:0]  rd;
    logic        illegal;
    logic [15:0] illegal_count;

    logic [31:0] lc_instr;
    logic        lc_legal;

    int total = 0;
    int bad   = 0;

    itype_issue_stage #(.CNT_W(16), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .rf_raddr      (rf_raddr),
        .rf_rdata      (rf_rdata),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .opcode        (opcode),
        .funct3        (funct3),
        .imm           (imm),
        .in1           (in1),
        .rd            (rd),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    itype_legal_check u_lc (
        .instr_i (lc_instr),
        .legal_o (lc_legal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        instr       = '0;
        rf_rdata    = '0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
    endtask

    function automatic logic [31:0] enc_addi(input logic [4:0] rd_v, input logic [4:0] rs1_v,
                                             input logic [11:0] imm_v);
        return {imm_v, rs1_v, 3'b000, rd_v, 7'b0010011};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        dec_ready = 1'b0;
        idle_inputs();
        lc_instr = '0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        total++; if (illegal_count !== 16'h0) begin bad++; $display("FAIL reset_count: got %h want 0000", illegal_count); end
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_instr_ready: got %b want 1", instr_ready); end
        total++;
        if ({opcode, funct3, imm, rd, in1} !== 59'd0) begin
            bad++; $display("FAIL reset_fields: got op=%h f3=%h imm=%h rd=%h in1=%h want all 0", opcode, funct3, imm, rd, in1);
        end
    endtask

    task automatic test_legality();
        logic [31:0] words [8] = '{32'hFFF08293, 32'h00311093, 32'h40001013, 32'h40415193,
                                   32'h20005013, 32'hFFF07013, 32'h00000033, 32'hFE003013};
        logic        want  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            lc_instr = words[i];
            #1;
            total++;
            if (lc_legal !== want[i]) begin
                bad++; $display("FAIL legal_check[%0d] %h: got %b want %b", i, words[i], lc_legal, want[i]);
            end
        end
    endtask

    task automatic test_addi();
        step();
        dec_ready   = 1'b1;
        instr_valid = 1'b1;
        instr       = 32'hFFF08293;
        #1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL addi_ready: got %b want 1", instr_ready); end
        total++; if (rf_raddr !== 5'd1) begin bad++; $display("FAIL addi_raddr: got %0d want 1", rf_raddr); end
        step();
        idle_inputs();
        rf_rdata = 32'h00000010;
        #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL addi_early_valid: got %b want 0", dec_valid); end
        step();
        rf_rdata = '0;
        #1;
        total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL addi_valid: got %b want 1", dec_valid); end
        total++;
        if (opcode !== 7'h13 || funct3 !== 3'd0 || imm !== 12'hFFF || in1 !== 32'h10 || rd !== 5'd5) begin
            bad++; $display("FAIL addi_fields: got op=%h f3=%h imm=%h in1=%h rd=%0d want 13 0 fff 00000010 5",
                            opcode, funct3, imm, in1, rd);
        end
        step();
        #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL addi_drain: got %b want 0", dec_valid); end
    endtask

    task automatic test_srai_bypass();
        step();
        instr_valid = 1'b1;
        instr       = 32'h40415193;
        step();
        idle_inputs();
        wb_en    = 1'b1;
        wb_addr  = 5'd2;
        wb_data  = 32'h80000000;
        rf_rdata = 32'h00000001;
        step();
        idle_inputs();
        #1;
        total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL srai_valid: got %b want 1", dec_valid); end
        total++;
        if (in1 !== 32'h80000000 || imm !== 12'h404 || funct3 !== 3'd5 || rd !== 5'd3) begin
            bad++; $display("FAIL srai_fields: got in1=%h imm=%h f3=%0d rd=%0d want 80000000 404 5 3", in1, imm, funct3, rd);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int   sent = 0;
        int   got = 0;
        logic acc_last = 1'b0;
        int   hs_cyc [4] = '{0, 0, 0, 0};
        for (int cyc = 0; cyc < 16; cyc++) begin
            step();
            if (acc_last) begin
                sent++;
                rf_rdata = 32'h100 + 32'(sent - 1);
            end else begin
                rf_rdata = '0;
            end
            if (cyc == 5) begin
                total++;
                if (sent !== 2) begin bad++; $display("FAIL stall_accepts: got %0d want 2", sent); end
            end
            instr_valid = (sent < 4);
            instr       = (sent < 4) ? enc_addi(5'(10 + sent), 5'(1 + sent), 12'(sent + 1)) : 32'h0;
            dec_ready   = (cyc >= 5);
            #1;
            acc_last = instr_valid && instr_ready;
            if (dec_valid) begin
                total++;
                if (got >= 4) begin
                    bad++; $display("FAIL stall_extra_output: got rd=%0d at cycle %0d want none", rd, cyc);
                end else if (rd !== 5'(10 + got) || in1 !== 32'h100 + 32'(got) || imm !== 12'(got + 1)) begin
                    bad++; $display("FAIL stall_out[%0d]: got rd=%0d in1=%h imm=%h want rd=%0d in1=%h imm=%h",
                                    got, rd, in1, imm, 10 + got, 32'h100 + 32'(got), got + 1);
                end
                if (dec_ready) begin
                    if (got < 4) hs_cyc[got] = cyc;
                    got++;
                end
            end
        end
        idle_inputs();
        total++; if (got !== 4) begin bad++; $display("FAIL stall_count: got %0d outputs want 4", got); end
        total++; if (hs_cyc[0] !== 5) begin bad++; $display("FAIL stall_first_hs: got cycle %0d want 5", hs_cyc[0]); end
        total++;
        if (hs_cyc[3] - hs_cyc[0] !== 3) begin
            bad++; $display("FAIL stall_rate: got span %0d cycles want 3", hs_cyc[3] - hs_cyc[0]);
        end
    endtask

    task automatic test_illegal();
        int pulses = 0;
        int dv = 0;
        dec_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            instr_valid = (cyc < 2);
            instr       = (cyc == 0) ? 32'h40001013 : ((cyc == 1) ? 32'h00000033 : 32'h0);
            #1;
            if (cyc == 1) begin
                total++;
                if (instr_ready !== 1'b1) begin bad++; $display("FAIL illegal_ready: got %b want 1", instr_ready); end
            end
            if (illegal) pulses++;
            if (dec_valid) dv++;
        end
        idle_inputs();
        total++; if (pulses !== 2) begin bad++; $display("FAIL illegal_pulses: got %0d want 2", pulses); end
        total++; if (dv !== 0) begin bad++; $display("FAIL illegal_dec_valid: got %0d cycles want 0", dv); end
        total++; if (illegal_count !== 16'd2) begin bad++; $display("FAIL illegal_count: got %0d want 2", illegal_count); end
    endtask

    task automatic test_rs1_zero();
        step();
        instr_valid = 1'b1;
        instr       = 32'h00500393;
        step();
        idle_inputs();
        rf_rdata = 32'hDEADBEEF;
        step();
        rf_rdata = '0;
        #1;
        total++;
        if (dec_valid !== 1'b1 || in1 !== 32'h0 || rd !== 5'd7 || imm !== 12'd5) begin
            bad++; $display("FAIL x0_operand: got v=%b in1=%h rd=%0d imm=%h want 1 00000000 7 005", dec_valid, in1, rd, imm);
        end
        step();
    endtask

    task automatic test_saturation();
        int sent = 0;
        dec_ready   = 1'b1;
        instr_valid = 1'b1;
        instr       = 32'h00000033;
        for (int cyc = 0; cyc < 70000 && sent < 65539; cyc++) begin
            #1;
            if (instr_ready) sent++;
            step();
        end
        idle_inputs();
        total++; if (sent !== 65539) begin bad++; $display("FAIL sat_timeout: got %0d accepts want 65539", sent); end
        repeat (4) step();
        total++; if (illegal_count !== 16'hFFFF) begin bad++; $display("FAIL sat_count: got %h want ffff", illegal_count); end
    endtask

    task automatic test_reset_midflight();
        dec_ready = 1'b0;
        step();
        instr_valid = 1'b1;
        instr       = enc_addi(5'd20, 5'd4, 12'h011);
        step();
        instr = enc_addi(5'd21, 5'd5, 12'h022);
        rf_rdata = 32'h55;
        step();
        idle_inputs();
        #1;
        total++;
        if (dec_valid !== 1'b1 || instr_ready !== 1'b0) begin
            bad++; $display("FAIL midflight_full: got v=%b rdy=%b want 1 0", dec_valid, instr_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL midflight_dec_valid: got %b want 0", dec_valid); end
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL midflight_ready: got %b want 1", instr_ready); end
        total++; if (illegal_count !== 16'h0) begin bad++; $display("FAIL midflight_count: got %h want 0000", illegal_count); end
        dec_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            step();
            total++;
            if (dec_valid !== 1'b0 || illegal !== 1'b0) begin
                bad++; $display("FAIL midflight_ghost[%0d]: got v=%b ill=%b want 0 0", cyc, dec_valid, illegal);
            end
        end
    endtask

    initial begin
        test_reset();
        test_legality();
        test_addi();
        test_srai_bypass();
        test_back_to_back();
        test_illegal();
        test_rs1_zero();
        test_saturation();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
